// File: rtl/lht_update_controller.sv
// Write sequencer for the local branch history table: clears every entry after
// reset, then issues one shift-in update per resolved branch in fetch order.
module lht_update_controller #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pc_valid,
  input  logic [PC_W-1:0]            pc,
  input  logic                       pc_is_branch,
  output logic                       fetch_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       tbl_we,
  output logic                       tbl_clear,
  output logic [IDX_W-1:0]           tbl_idx,
  output logic                       tbl_taken,
  output logic [$clog2(DEPTH):0]     pending_count,
  output logic                       init_done,
  output logic                       resolve_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state, state_next;
  logic [IDX_W:0]     sweep_cnt;
  logic               sweep_done;
  logic [IDX_W-1:0]   queue_mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic               push, pop;

  logic               we_next, clear_next, taken_next, done_next, err_next;
  logic [IDX_W-1:0]   idx_next;

  // Only the low index bits address the table; the rest of the PC is unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[PC_W-1:IDX_W];

  // The counter's top bit marks that every entry has been written once.
  assign sweep_done  = sweep_cnt[IDX_W];
  assign fetch_ready = (state == RUN) && (pending_count < CNT_W'(DEPTH));
  assign push        = pc_valid & pc_is_branch & fetch_ready & ~flush;
  assign pop         = (state == RUN) & resolve_valid & (pending_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && sweep_done) state_next = RUN;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    we_next    = 1'b0;
    clear_next = 1'b0;
    idx_next   = tbl_idx;
    taken_next = 1'b0;
    done_next  = init_done;
    err_next   = resolve_err;
    unique case (state)
      CLEAR: begin
        if (!sweep_done) begin
          we_next    = 1'b1;
          clear_next = 1'b1;
          idx_next   = sweep_cnt[IDX_W-1:0];
        end else begin
          done_next  = 1'b1;
        end
      end
      RUN: begin
        if (pop) begin
          we_next    = 1'b1;
          idx_next   = queue_mem[head];
          taken_next = resolve_taken;
        end
        if (resolve_valid && pending_count == '0) err_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tbl_we      <= 1'b0;
      tbl_clear   <= 1'b0;
      tbl_idx     <= '0;
      tbl_taken   <= 1'b0;
      init_done   <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      tbl_we      <= we_next;
      tbl_clear   <= clear_next;
      tbl_idx     <= idx_next;
      tbl_taken   <= taken_next;
      init_done   <= done_next;
      resolve_err <= err_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep_cnt     <= '0;
      head          <= '0;
      tail          <= '0;
      pending_count <= '0;
    end else begin
      if (state == CLEAR && !sweep_done) sweep_cnt <= sweep_cnt + 1'b1;
      if (state == RUN && flush) begin
        // A same-cycle resolve has already been captured into the write port.
        head          <= '0;
        tail          <= '0;
        pending_count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        unique case ({push, pop})
          2'b10:   pending_count <= pending_count + 1'b1;
          2'b01:   pending_count <= pending_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; occupancy is tracked by the pointers and
  // count, so stale entries are never read.
  always_ff @(posedge clock) begin
    if (push) queue_mem[tail] <= pc[IDX_W-1:0];
  end

endmodule

// File: tb/tb_lht_update_controller.sv
// Directed bench for lht_update_controller: clear sweep, single and queued
// resolves, push/pop wrap, flush, and empty-queue resolve error.
module tb_lht_update_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_is_branch = 1'b0;
  logic        fetch_ready;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic        flush = 1'b0;
  logic        tbl_we, tbl_clear, tbl_taken, init_done, resolve_err;
  logic [9:0]  tbl_idx;
  logic [2:0]  pending_count;

  int tests_run = 0;
  int tests_failed = 0;

  lht_update_controller #(.IDX_W(10), .DEPTH(4), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .pc_valid(pc_valid), .pc(pc),
    .pc_is_branch(pc_is_branch), .fetch_ready(fetch_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .tbl_we(tbl_we), .tbl_clear(tbl_clear), .tbl_idx(tbl_idx), .tbl_taken(tbl_taken),
    .pending_count(pending_count), .init_done(init_done), .resolve_err(resolve_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pc_valid = 1'b0; pc_is_branch = 1'b0; pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
  endtask

  task automatic push_pc(input logic [31:0] p);
    pc_valid = 1'b1; pc_is_branch = 1'b1; pc = p;
    tick();
    idle_inputs();
  endtask

  // Checks n sweep cycles while fetch/resolve/flush are held active.
  task automatic sweep_cycles(input int n);
    logic [9:0] exp_idx;
    pc_valid = 1'b1; pc_is_branch = 1'b1; pc = 32'h55;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_idx = k[9:0];
      tests_run++;
      if (fetch_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_fetch_ready cycle %0d: got %b want 0", k, fetch_ready);
      end
      tick();
      tests_run++;
      if (tbl_we !== 1'b1 || tbl_clear !== 1'b1 || tbl_idx !== exp_idx ||
          tbl_taken !== 1'b0 || init_done !== 1'b0 || pending_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL sweep_write cycle %0d: we=%b clr=%b idx=%0d tk=%b done=%b cnt=%0d want 1 1 %0d 0 0 0",
                 k, tbl_we, tbl_clear, tbl_idx, tbl_taken, init_done, pending_count, exp_idx);
      end
    end
    idle_inputs();
  endtask

  task automatic finish_sweep();
    tick();
    tests_run++;
    if (tbl_we !== 1'b0 || tbl_clear !== 1'b0 || init_done !== 1'b1 ||
        fetch_ready !== 1'b1 || pending_count !== 3'd0 || resolve_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_end: we=%b clr=%b done=%b rdy=%b cnt=%0d err=%b want 0 0 1 1 0 0",
               tbl_we, tbl_clear, init_done, fetch_ready, pending_count, resolve_err);
    end
  endtask

  task automatic check_write(input string name, input logic [9:0] idx, input logic tk,
                             input logic [2:0] cnt);
    tests_run++;
    if (tbl_we !== 1'b1 || tbl_clear !== 1'b0 || tbl_idx !== idx ||
        tbl_taken !== tk || pending_count !== cnt) begin
      tests_failed++;
      $display("FAIL %s: we=%b clr=%b idx=%h tk=%b cnt=%0d want 1 0 %h %b %0d",
               name, tbl_we, tbl_clear, tbl_idx, tbl_taken, pending_count, idx, tk, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests_run++;
    if (tbl_we !== 1'b0 || tbl_clear !== 1'b0 || tbl_idx !== 10'd0 || tbl_taken !== 1'b0 ||
        pending_count !== 3'd0 || init_done !== 1'b0 || resolve_err !== 1'b0 || fetch_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: we=%b clr=%b idx=%0d tk=%b cnt=%0d done=%b err=%b rdy=%b want all 0",
               tbl_we, tbl_clear, tbl_idx, tbl_taken, pending_count, init_done, resolve_err, fetch_ready);
    end
    tick();
    reset = 1'b0;
    sweep_cycles(1024);
    finish_sweep();
  endtask

  task automatic test_single_branch();
    pc_valid = 1'b1; pc_is_branch = 1'b1; pc = 32'd1234;
    tests_run++;
    if (fetch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready: got %b want 1", fetch_ready);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (pending_count !== 3'd1 || tbl_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_push: cnt=%0d we=%b want 1 0", pending_count, tbl_we);
    end
    tick();
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    idle_inputs();
    check_write("single_resolve", 10'd210, 1'b1, 3'd0);
    tick();
    tests_run++;
    if (tbl_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_we_drop: got %b want 0", tbl_we);
    end
  endtask

  task automatic test_full_queue();
    push_pc(32'h10); push_pc(32'h11); push_pc(32'h12); push_pc(32'h13);
    tests_run++;
    if (fetch_ready !== 1'b0 || pending_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_state: rdy=%b cnt=%0d want 0 4", fetch_ready, pending_count);
    end
    pc_valid = 1'b1; pc_is_branch = 1'b1; pc = 32'h14;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    idle_inputs();
    check_write("full_pop0", 10'h10, 1'b1, 3'd3);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    tick();
    check_write("full_pop1", 10'h11, 1'b0, 3'd2);
    resolve_taken = 1'b1;
    tick();
    check_write("full_pop2", 10'h12, 1'b1, 3'd1);
    resolve_taken = 1'b0;
    tick();
    check_write("full_pop3", 10'h13, 1'b0, 3'd0);
    idle_inputs();
    tick();
    tests_run++;
    if (tbl_we !== 1'b0 || pending_count !== 3'd0 || resolve_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drained: we=%b cnt=%0d err=%b want 0 0 0", tbl_we, pending_count, resolve_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_q[$];
    logic [9:0] exp_idx;
    logic [31:0] new_pc;
    push_pc(32'h100); exp_q.push_back(10'h100);
    push_pc(32'h101); exp_q.push_back(10'h101);
    for (int i = 0; i < 10; i++) begin
      new_pc = 32'h180 + 32'(i * 3);
      pc_valid = 1'b1; pc_is_branch = 1'b1; pc = new_pc;
      resolve_valid = 1'b1; resolve_taken = i[0];
      tick();
      exp_idx = exp_q.pop_front();
      exp_q.push_back(new_pc[9:0]);
      check_write("b2b_swap", exp_idx, i[0], 3'd2);
    end
    idle_inputs();
    for (int j = 0; j < 2; j++) begin
      resolve_valid = 1'b1; resolve_taken = 1'b1;
      tick();
      exp_idx = exp_q.pop_front();
      check_write("b2b_drain", exp_idx, 1'b1, 3'(1 - j));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    push_pc(32'h200); push_pc(32'h201); push_pc(32'h202);
    tests_run++;
    if (pending_count !== 3'd3) begin
      tests_failed++;
      $display("FAIL flush_prefill: cnt=%0d want 3", pending_count);
    end
    flush = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b0;
    pc_valid = 1'b1; pc_is_branch = 1'b1; pc = 32'h3ff;
    tick();
    idle_inputs();
    check_write("flush_head_write", 10'h200, 1'b0, 3'd0);
    tick();
    tests_run++;
    if (tbl_we !== 1'b0 || pending_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_after: we=%b cnt=%0d want 0 0", tbl_we, pending_count);
    end
    push_pc(32'h055);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    idle_inputs();
    check_write("flush_fresh_head", 10'h055, 1'b1, 3'd0);
  endtask

  task automatic test_empty_resolve();
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (tbl_we !== 1'b0 || resolve_err !== 1'b1 || pending_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL empty_resolve: we=%b err=%b cnt=%0d want 0 1 0", tbl_we, resolve_err, pending_count);
    end
    repeat (3) tick();
    tests_run++;
    if (resolve_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b want 1", resolve_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_cycles(501);
    reset = 1'b1;
    #2;
    tests_run++;
    if (tbl_we !== 1'b0 || tbl_clear !== 1'b0 || tbl_idx !== 10'd0 ||
        init_done !== 1'b0 || resolve_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_sweep_reset: we=%b clr=%b idx=%0d done=%b err=%b want 0 0 0 0 0",
               tbl_we, tbl_clear, tbl_idx, init_done, resolve_err);
    end
    tick();
    reset = 1'b0;
    sweep_cycles(1024);
    finish_sweep();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_branch();
    test_full_queue();
    test_back_to_back();
    test_flush();
    test_empty_resolve();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
